// File: rtl/display_share_arbiter.sv
// Round-robin owner selection for the shared 8-digit hex display, with a minimum dwell before preemption.
// Optional DISPLAY_ARB_HOLD_LAST_EN keeps the last owner's word and index on the display while idle.
module display_share_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter logic [31:0] DWELL_CYCLES = 32'd65_000_000
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_REQ-1:0]         req_in,
    input  logic [32*NUM_REQ-1:0]      data_in,
    output logic [NUM_REQ-1:0]         grant_out,
    output logic [$clog2(NUM_REQ)-1:0] owner_out,
    output logic [31:0]                data_out,
    output logic                       busy_out
);

    localparam int          IDX_W      = $clog2(NUM_REQ);
    localparam logic [31:0] LAST_COUNT = DWELL_CYCLES - 32'd1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state, state_next;
    logic [31:0]        count, count_next;
    logic [IDX_W-1:0]   ptr, ptr_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [IDX_W-1:0]   owner_next;
    logic [31:0]        data_next;
    logic               busy_next;

    logic [NUM_REQ-1:0] candidates;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_req;
    logic               saturated;
    logic               do_grant;
    logic               do_release;

    // First set bit at or after start, wrapping; result is {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   start);
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (IDX_W'(i) >= start)) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [31:0] slice_of(input logic [32*NUM_REQ-1:0] words,
                                             input logic [IDX_W-1:0]      idx);
        logic [31:0] word;
        word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == idx) begin
                word = words[32*i +: 32];
            end
        end
        return word;
    endfunction

    // grant_out is zero in IDLE, so masking it off leaves only the other requesters while holding.
    // ptr always equals owner+1 during HOLD, so one search serves both states.
    assign candidates             = req_in & ~grant_out;
    assign {pick_valid, pick_idx} = rr_pick(candidates, ptr);
    assign owner_req              = |(req_in & grant_out);
    assign saturated              = (count == LAST_COUNT);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            count     <= '0;
            ptr       <= '0;
            grant_out <= '0;
            owner_out <= '0;
            data_out  <= '0;
            busy_out  <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            ptr       <= ptr_next;
            grant_out <= grant_next;
            owner_out <= owner_next;
            data_out  <= data_next;
            busy_out  <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_release = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    do_grant   = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!owner_req) begin
                    if (pick_valid) begin
                        do_grant = 1'b1;
                    end else begin
                        do_release = 1'b1;
                        state_next = IDLE;
                    end
                end else if (saturated && pick_valid) begin
                    do_grant = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_next = grant_out;
        owner_next = owner_out;
        data_next  = data_out;
        busy_next  = busy_out;
        count_next = count;
        ptr_next   = ptr;
        if (do_grant) begin
            grant_next = NUM_REQ'(1) << pick_idx;
            owner_next = pick_idx;
            data_next  = slice_of(data_in, pick_idx);
            busy_next  = 1'b1;
            count_next = '0;
            ptr_next   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end else if (do_release) begin
            grant_next = '0;
            busy_next  = 1'b0;
            count_next = '0;
`ifdef DISPLAY_ARB_HOLD_LAST_EN
            data_next  = data_out;
            owner_next = owner_out;
`else
            data_next  = '0;
            owner_next = '0;
`endif
        end else if (state == HOLD) begin
            // Live producers keep updating the display while they own it.
            data_next = slice_of(data_in, owner_out);
            if (!saturated) begin
                count_next = count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter with NUM_REQ=4 and DWELL_CYCLES=8.
// Idle expectations follow DISPLAY_ARB_HOLD_LAST_EN when it is defined for the build.
module tb_display_share_arbiter;

    localparam int NUM_REQ = 4;

`ifdef DISPLAY_ARB_HOLD_LAST_EN
    localparam bit HOLD_LAST = 1'b1;
`else
    localparam bit HOLD_LAST = 1'b0;
`endif

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic [NUM_REQ-1:0]    req_in;
    logic [32*NUM_REQ-1:0] data_in;
    logic [NUM_REQ-1:0]    grant_out;
    logic [1:0]            owner_out;
    logic [31:0]           data_out;
    logic                  busy_out;

    int vectors     = 0;
    int miscompares = 0;

    display_share_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DWELL_CYCLES (32'd8)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .req_in    (req_in),
        .data_in   (data_in),
        .grant_out (grant_out),
        .owner_out (owner_out),
        .data_out  (data_out),
        .busy_out  (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_slice(input int idx, input logic [31:0] value);
        data_in[32*idx +: 32] = value;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_output(input string tag, input logic [3:0] exp_grant, input logic [1:0] exp_owner,
                                input logic exp_busy, input logic [31:0] exp_data);
        check({tag, ".grant"}, 32'(grant_out), 32'(exp_grant));
        check({tag, ".owner"}, 32'(owner_out), 32'(exp_owner));
        check({tag, ".busy"},  32'(busy_out),  32'(exp_busy));
        check({tag, ".data"},  data_out,       exp_data);
    endtask

    initial begin
        rst_in  = 1'b1;
        req_in  = '0;
        data_in = '0;
        set_slice(0, 32'h1111_1111);
        set_slice(1, 32'h2222_2222);
        set_slice(2, 32'hDEAD_BEEF);
        set_slice(3, 32'h4444_4444);
        #2;
        check_output("reset", 4'b0000, 2'd0, 1'b0, 32'h0);
        step();
        rst_in = 1'b0;

        // Single requester, then a live data update, then release to idle.
        req_in = 4'b0100;
        step();
        check_output("single_grant", 4'b0100, 2'd2, 1'b1, 32'hDEAD_BEEF);
        set_slice(2, 32'h1234_5678);
        step();
        check("single_follow", data_out, 32'h1234_5678);
        req_in = 4'b0000;
        step();
        check_output("single_idle", 4'b0000, HOLD_LAST ? 2'd2 : 2'd0, 1'b0,
                     HOLD_LAST ? 32'h1234_5678 : 32'h0);

        // Two requesters alternate every dwell; ptr=3 so requester 0 wins first.
        req_in = 4'b0011;
        for (int k = 0; k < 32; k++) begin
            step();
            check("contention_grant", 32'(grant_out), ((k / 8) % 2 == 0) ? 32'h1 : 32'h2);
        end
        step();
        check("contention_wrap", 32'(grant_out), 32'h1);

        // Owner 0 drops at count 3; owner 1 gets a full fresh dwell.
        step();
        step();
        step();
        check("early_before", 32'(grant_out), 32'h1);
        req_in = 4'b0010;
        step();
        check_output("early_release", 4'b0010, 2'd1, 1'b1, 32'h2222_2222);
        req_in = 4'b0011;
        for (int k = 0; k < 7; k++) step();
        check("fresh_dwell_end", 32'(grant_out), 32'h2);
        step();
        check("fresh_dwell_next", 32'(grant_out), 32'h1);

        // Owner 3 expires with 1101 pending: next is requester 0, not 2.
        req_in = 4'b1000;
        step();
        check_output("wrap_owner3", 4'b1000, 2'd3, 1'b1, 32'h4444_4444);
        req_in = 4'b1101;
        for (int k = 0; k < 7; k++) step();
        check("wrap_hold", 32'(grant_out), 32'h8);
        step();
        check_output("wrap_next", 4'b0001, 2'd0, 1'b1, 32'h1111_1111);

        // Asynchronous reset at count 5, between clock edges.
        for (int k = 0; k < 5; k++) step();
        #2;
        rst_in = 1'b1;
        #1;
        check_output("reset_async", 4'b0000, 2'd0, 1'b0, 32'h0);
        #1;
        rst_in = 1'b0;
        req_in = 4'b1010;
        step();
        check_output("reset_first", 4'b0010, 2'd1, 1'b1, 32'h2222_2222);

        // Owner drops with nothing else pending.
        req_in = 4'b0000;
        step();
        check_output("idle", 4'b0000, HOLD_LAST ? 2'd1 : 2'd0, 1'b0,
                     HOLD_LAST ? 32'h2222_2222 : 32'h0);
        step();
        check_output("idle_stay", 4'b0000, HOLD_LAST ? 2'd1 : 2'd0, 1'b0,
                     HOLD_LAST ? 32'h2222_2222 : 32'h0);

        // Lone owner saturates, then a late arrival preempts on the next edge.
        req_in = 4'b0001;
        step();
        check("sat_grant", 32'(grant_out), 32'h1);
        for (int k = 0; k < 12; k++) step();
        check("sat_keep", 32'(grant_out), 32'h1);
        req_in = 4'b0101;
        step();
        check_output("sat_preempt", 4'b0100, 2'd2, 1'b1, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_share_arbiter.md
# display_share_arbiter

Round-robin arbiter that shares the single 8-digit seven-segment display between up to NUM_REQ producers (debug counters, FSM state, audio levels, and so on). Each producer raises a request with a 32-bit word of eight hex nibbles. The arbiter grants the display to one producer at a time and guarantees a minimum dwell time before another producer can preempt it. `data_out` drives the 8-hex display driver's `data_in` directly.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- DWELL_CYCLES, 65_000_000: minimum ownership in clk_in cycles before preemption (1 s at 65 MHz); legal range 1..2^32-1.
- clk_in  in  1  system clock.
- rst_in  in  1  reset. One clock; reset is asynchronous and active-high.
- req_in  in  NUM_REQ  per-requester request; level-sensitive.
- data_in  in  32*NUM_REQ  requester i's word is at bits [32*i+31 : 32*i], msb nibble first.
- grant_out  out  NUM_REQ  one-hot current owner; all zero when idle.
- owner_out  out  clog2(NUM_REQ)  index of the current or last owner.
- data_out  out  32  word sent to the display.
- busy_out  out  1  high while any requester owns the display.

## Operation
- Two states: IDLE and HOLD. A 32-bit dwell counter and a round-robin pointer `ptr` track ownership; `ptr` holds the index searched first.
- **IDLE:**
  - If any req_in is high, grant the first requester at or after `ptr`, searching upward modulo NUM_REQ.
  - Go to HOLD and clear the counter.
- **HOLD:**
  - The counter increments each cycle and saturates at DWELL_CYCLES-1.
  - data_out reloads from the owner's data_in slice every cycle, so a live value keeps updating on the display.
- **Owner drops req_in, at any counter value:**
  - Ownership ends immediately.
  - If another requester is pending, grant the next one in round-robin order starting at owner+1, with no idle cycle; clear the counter.
  - Otherwise go to IDLE.
- **Counter reaches DWELL_CYCLES-1 with the owner still requesting:**
  - If another requester is pending, grant the next one in round-robin order starting at owner+1; clear the counter.
  - Otherwise keep the owner; the counter stays saturated.
- **Preemption:**
  - Before the dwell expires, other requests are ignored.
  - After it expires, a newly arriving request preempts on the next edge.
- Every grant sets `ptr` to grant index + 1, wrapping from NUM_REQ-1 to 0.
- Simultaneous requests are resolved only by round-robin order; no requester has fixed priority.
- Reset values: grant_out=0, owner_out=0, data_out=0, busy_out=0, state=IDLE, counter=0, ptr=0.

## Timing
- All outputs are registered.
- A req_in rise sampled at edge t (IDLE) produces grant_out, owner_out, busy_out and data_out (the new owner's slice) after edge t; the response latency is 1 cycle.
- Handover: the old grant deasserts and the new one asserts on the same edge.
  - grant_out is never zero between back-to-back owners.
  - grant_out is never multi-hot.
- Owner tenure under contention is exactly DWELL_CYCLES cycles.
- A req_in drop sampled at edge t releases the grant after edge t.
- rst_in asserted mid-HOLD clears all outputs asynchronously, without waiting for a clock edge.
- After rst_in deasserts, the first arbitration starts its search at requester 0.

## Configuration
- DISPLAY_ARB_HOLD_LAST_EN defined:
  - In IDLE, data_out holds the last owner's final word.
  - owner_out keeps the last index.
- DISPLAY_ARB_HOLD_LAST_EN undefined:
  - On entering IDLE, data_out becomes 32'h0000_0000 on the same edge grant_out clears.
  - owner_out becomes 0 on that edge.

## Test plan
All scenarios use NUM_REQ=4 and DWELL_CYCLES=8.
- **Single requester:** req_in=4'b0100 with slice 2 = 32'hDEAD_BEEF, raised before edge t -> after edge t: grant_out=4'b0100, owner_out=2, busy_out=1, data_out=32'hDEAD_BEEF. Change the slice to 32'h1234_5678 -> data_out follows 1 cycle later.
- **Contention:** req_in=4'b0011 held for 32 cycles -> grant_out alternates 0001/0010 every 8 cycles. No zero or multi-hot grant cycle is ever observed.
- **Early release:** owner 0 drops its request at count 3 while req 1 is pending -> grant_out=4'b0010 on the next edge. Owner 1 gets a fresh 8-cycle dwell.
- **Wrap-around:** owner 3's dwell expires with req_in=4'b1101 -> the next grant is 4'b0001 (requester 0), not requester 2.
- **Reset mid-hold:** pulse rst_in between clock edges at count 5 -> all outputs become 0 immediately. After release, req_in=4'b1010 -> requester 1 is granted first.
- **Idle behaviour:** the owner drops its request with no others pending -> grant_out=0 and busy_out=0. data_out holds its last value when DISPLAY_ARB_HOLD_LAST_EN is defined, and becomes 32'h0 when it is not.
